// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, result-half select constants and counter sizing.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic SEL_HIGH = 1'b1;
  localparam logic SEL_LOW = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one recode/add/shift iteration; BOOTH_SIGNED_EN selects signed Booth vs unsigned shift-add.
module booth_step #(
  parameter int width = 32
) (
  input  logic [width-1:0]   a,
  input  logic [2*width+1:0] p,
  output logic [2*width+1:0] p_next
);
  logic [width:0] acc, a_ext, sum;
  assign acc = p[2*width+1:width+1];
`ifdef BOOTH_SIGNED_EN
  assign a_ext = {a[width-1], a};
  assign sum = (p[1:0] == 2'b01) ? acc + a_ext : (p[1:0] == 2'b10) ? acc - a_ext : acc;
  assign p_next = $signed({sum, p[width:0]}) >>> 1;
`else
  assign a_ext = {1'b0, a};
  assign sum = p[1] ? acc + a_ext : acc;
  assign p_next = {sum, p[width:0]} >> 1;
`endif
endmodule

// File: rtl/booth_algorithm_multiplier.sv
// booth_algorithm_multiplier: iterative width-cycle multiplier returning one product half.
// Define BOOTH_SIGNED_EN for two's complement operands; unsigned otherwise.
module booth_algorithm_multiplier
  import mul_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [width-1:0] multiplicand,
  input  logic [width-1:0] multiplier,
  input  logic             return_high_or_low,
  input  logic             start_flag,
  output logic             busy_o,
  output logic             valid_o,
  output logic             error_o,
  output logic [width-1:0] result_o
);
  localparam int CW = cnt_w(width);
  state_t state;
  logic [2*width+1:0] p, p_next;
  logic [width-1:0] a, hi, lo;
  logic sel, ovf;
  logic [CW-1:0] count;
  booth_step #(.width(width)) u_step (.a(a), .p(p), .p_next(p_next));
  assign hi = p[2*width:width+1];
  assign lo = p[width:1];
`ifdef BOOTH_SIGNED_EN
  assign ovf = hi != {width{lo[width-1]}};
`else
  assign ovf = |hi;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      p        <= '0;
      a        <= '0;
      sel      <= SEL_LOW;
      count    <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (start_flag) begin
            p       <= {{(width+1){1'b0}}, multiplier, 1'b0};
            a       <= multiplicand;
            sel     <= return_high_or_low;
            count   <= CW'(width);
            busy_o  <= 1'b1;
            error_o <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          p     <= p_next;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= DONE;
        end
        DONE: begin
          valid_o  <= 1'b1;
          busy_o   <= 1'b0;
          result_o <= (sel == SEL_HIGH) ? hi : lo;
          if (sel == SEL_LOW && ovf) error_o <= 1'b1;
          p[2*width+1:width+1] <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
